// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory stage:
// opcodes, exception causes, FSM states.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'd20;
  localparam logic [5:0] OP_LH  = 6'd21;
  localparam logic [5:0] OP_LW  = 6'd22;
  localparam logic [5:0] OP_LBU = 6'd23;
  localparam logic [5:0] OP_LHU = 6'd24;
  localparam logic [5:0] OP_SB  = 6'd25;
  localparam logic [5:0] OP_SH  = 6'd26;
  localparam logic [5:0] OP_SW  = 6'd27;

  localparam logic [1:0] CAUSE_LD_MIS = 2'd0;
  localparam logic [1:0] CAUSE_ST_MIS = 2'd1;
  localparam logic [1:0] CAUSE_LD_ERR = 2'd2;
  localparam logic [1:0] CAUSE_ST_ERR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus request/grant/response interface
// between the load/store unit and memory.
interface mem_access_unit_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_wstrb,
    input  bus_gnt,
    input  bus_rvalid,
    input  bus_rdata,
    input  bus_err
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_wstrb,
    output bus_gnt,
    output bus_rvalid,
    output bus_rdata,
    output bus_err
  );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// Load data lane selection and
// sign/zero extension.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [5:0]  instr_id_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  // pick the addressed lane, then extend
  always_comb begin
    byte_w = rdata_i[{addr_i, 3'b000} +: 8];
    half_w = addr_i[1] ? rdata_i[31:16]
                       : rdata_i[15:0];
    unique case (instr_id_i)
      OP_LB:   data_o = {{24{byte_w[7]}}, byte_w};
      OP_LBU:  data_o = {24'd0, byte_w};
      OP_LH:   data_o = {{16{half_w[15]}}, half_w};
      OP_LHU:  data_o = {16'd0, half_w};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one bus
// transaction at a time, stalls EX_MEM.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [5:0]  instr_id_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] rs2_value_in,
  input  logic [31:0] exec_output_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        rd_valid_in,
  mem_access_unit_if.master bus,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_rd_valid,
  output logic [31:0] wb_result,
  output logic        mem_exc,
  output logic [1:0]  mem_exc_cause
);

  state_e      state_q;
  state_e      state_d;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] load_q;
  logic        err_q;
  logic        exc_q;

  logic        is_load;
  logic        is_store;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        misal;
  logic        go;
  logic [31:0] wdata_w;
  logic [3:0]  wstrb_w;
  logic [31:0] ld_data;

  load_align u_align (
    .rdata_i    (bus.bus_rdata),
    .addr_i     (mem_addr_in[1:0]),
    .instr_id_i (instr_id_in),
    .data_o     (ld_data)
  );

  // decode the slot and build store lanes
  always_comb begin
    is_load  = valid_in &&
      (instr_id_in inside
        {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU});
    is_store = valid_in &&
      (instr_id_in inside {OP_SB, OP_SH, OP_SW});
    is_byte  = instr_id_in inside
      {OP_LB, OP_LBU, OP_SB};
    is_half  = instr_id_in inside
      {OP_LH, OP_LHU, OP_SH};
    is_word  = instr_id_in inside {OP_LW, OP_SW};
    misal    = (is_load || is_store) &&
      ((is_half && mem_addr_in[0]) ||
       (is_word && (mem_addr_in[1:0] != 2'b00)));
    go       = (is_load || is_store) && !misal;
    wstrb_w  = 4'b1111;
    wdata_w  = rs2_value_in;
    unique case (1'b1)
      is_byte: begin
        wstrb_w = 4'b0001 << mem_addr_in[1:0];
        wdata_w = {4{rs2_value_in[7:0]}};
      end
      is_half: begin
        wstrb_w = 4'b0011 << mem_addr_in[1:0];
        wdata_w = {2{rs2_value_in[15:0]}};
      end
      default: ;
    endcase
  end

  // transaction sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (go) state_d = S_REQ;
      S_REQ:
        if (bus.bus_gnt)
          state_d = is_store ? S_DONE : S_RESP;
      S_RESP: if (bus.bus_rvalid) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // registered bus payload, held through REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else if (state_q == S_IDLE && go) begin
      req_q   <= 1'b1;
      we_q    <= is_store;
      addr_q  <= {mem_addr_in[31:2], 2'b00};
      wdata_q <= is_store ? wdata_w : 32'd0;
      wstrb_q <= is_store ? wstrb_w : 4'd0;
    end else if (state_q == S_REQ && bus.bus_gnt) begin
      req_q   <= 1'b0;
    end
  end

  // load data, error flag and DONE-entry pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q <= 32'd0;
      err_q  <= 1'b0;
      exc_q  <= 1'b0;
    end else begin
      exc_q <= 1'b0;
      if (state_q == S_IDLE && go) begin
        err_q <= 1'b0;
      end else if (state_q == S_REQ &&
                   bus.bus_gnt && is_store) begin
        err_q <= bus.bus_err;
        exc_q <= bus.bus_err;
      end else if (state_q == S_RESP &&
                   bus.bus_rvalid) begin
        load_q <= ld_data;
        err_q  <= bus.bus_err;
        exc_q  <= bus.bus_err;
      end
    end
  end

  // writeback, stall and exception outputs
  always_comb begin
    wb_valid    = valid_in;
    wb_result   = exec_output_in;
    wb_rd_valid = rd_valid_in && valid_in;
    if (misal) begin
      wb_valid    = 1'b1;
      wb_rd_valid = 1'b0;
    end else if (go) begin
      wb_valid    = (state_q == S_DONE);
      wb_result   = is_load ? load_q
                            : exec_output_in;
      wb_rd_valid = (state_q == S_DONE) &&
        is_load && rd_valid_in && !err_q;
    end
    mem_stall = go && (state_q != S_DONE);
    mem_exc   = misal || exc_q;
    if (misal)
      mem_exc_cause = is_store ? CAUSE_ST_MIS
                               : CAUSE_LD_MIS;
    else if (exc_q)
      mem_exc_cause = is_store ? CAUSE_ST_ERR
                               : CAUSE_LD_ERR;
    else
      mem_exc_cause = 2'd0;
  end

  assign wb_rd_addr    = rd_addr_in;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit:
// directed cases plus randomized ops.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [5:0]  instr_id_in;
  logic [31:0] mem_addr_in;
  logic [31:0] rs2_value_in;
  logic [31:0] exec_output_in;
  logic [4:0]  rd_addr_in;
  logic        rd_valid_in;
  logic        mem_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_valid;
  logic [31:0] wb_result;
  logic        mem_exc;
  logic [1:0]  mem_exc_cause;

  mem_access_unit_if bus_if ();

  mem_access_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .instr_id_in    (instr_id_in),
    .mem_addr_in    (mem_addr_in),
    .rs2_value_in   (rs2_value_in),
    .exec_output_in (exec_output_in),
    .rd_addr_in     (rd_addr_in),
    .rd_valid_in    (rd_valid_in),
    .bus            (bus_if.master),
    .mem_stall      (mem_stall),
    .wb_valid       (wb_valid),
    .wb_rd_addr     (wb_rd_addr),
    .wb_rd_valid    (wb_rd_valid),
    .wb_result      (wb_result),
    .mem_exc        (mem_exc),
    .mem_exc_cause  (mem_exc_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // observations from the last op
  int          o_cyc, o_nstall, o_nreq, o_nexc;
  bit          o_done, o_stable;
  logic        o_we, o_rdv;
  logic [31:0] o_addr, o_wdata, o_res;
  logic [3:0]  o_wstrb;
  logic [4:0]  o_rda;
  logic [1:0]  o_cause;

  // model expectations for the last op
  int          e_cyc, e_nstall, e_nreq, e_nexc;
  bit          e_mem, e_ld;
  logic        e_we, e_rdv;
  logic [31:0] e_addr, e_wdata, e_res;
  logic [3:0]  e_wstrb;
  logic [1:0]  e_cause;

  task automatic model(
    input logic [5:0]  id,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [31:0] ex,
    input logic        rdv,
    input int          gd,
    input int          rdl,
    input logic [31:0] rdat,
    input logic        er);
    bit ld, st;
    int sz, off;
    logic [31:0] v;
    ld = (id >= 20 && id <= 24);
    st = (id >= 25 && id <= 27);
    sz = (id == 20 || id == 23 || id == 25) ? 1 :
         (id == 21 || id == 24 || id == 26) ? 2 : 4;
    off = int'(a % 4);
    e_mem = 0; e_ld = ld; e_nexc = 0;
    e_cause = 2'd0; e_we = st;
    e_addr = a - 32'(off);
    e_wstrb = 4'd0; e_wdata = 32'd0;
    e_res = ex; e_rdv = rdv;
    e_cyc = 0; e_nreq = 0; e_nstall = 0;
    if (ld || st) begin
      e_rdv = 1'b0;
      if (off % sz != 0) begin
        e_nexc = 1;
        e_cause = st ? 2'd1 : 2'd0;
      end else begin
        e_mem = 1;
        e_nreq = 1 + gd;
        e_cyc = st ? 2 + gd : 3 + gd + rdl;
        e_nstall = e_cyc;
        if (st) begin
          e_wstrb = 4'(((1 << sz) - 1) << off);
          if (sz == 1)
            e_wdata = (d % 256) * 32'h01010101;
          else if (sz == 2)
            e_wdata = (d % 65536) * 32'h00010001;
          else
            e_wdata = d;
        end else begin
          v = rdat >> (8 * off);
          if (sz < 4)
            v = v % (32'd1 << (8 * sz));
          if (id == 20 && v >= 128)
            v = v + 32'hFFFFFF00;
          if (id == 21 && v >= 32768)
            v = v + 32'hFFFF0000;
          e_res = v;
          e_rdv = rdv && !er;
        end
        if (er) begin
          e_nexc = 1;
          e_cause = st ? 2'd3 : 2'd2;
        end
      end
    end
  endtask

  // drive one op at posedge+1, act as bus
  // slave, return at posedge+1 after wb
  task automatic do_op(
    input logic [5:0]  id,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [31:0] ex,
    input logic [4:0]  rd,
    input logic        rdv,
    input int          gd,
    input int          rdl,
    input logic [31:0] rdat,
    input logic        er);
    int gw, rw;
    bit granted, responded, st;
    st = (id >= 25 && id <= 27);
    valid_in = 1'b1; instr_id_in = id;
    mem_addr_in = a; rs2_value_in = d;
    exec_output_in = ex; rd_addr_in = rd;
    rd_valid_in = rdv;
    bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0;
    bus_if.bus_err = 0; bus_if.bus_rdata = 0;
    o_cyc = -1; o_nstall = 0; o_nreq = 0;
    o_nexc = 0; o_done = 0; o_stable = 1;
    o_cause = 0; o_res = 0; o_rdv = 0;
    o_rda = 0; o_we = 0; o_addr = 0;
    o_wdata = 0; o_wstrb = 0;
    gw = 0; rw = 0; granted = 0; responded = 0;
    for (int c = 0; c < 64 && !o_done; c++) begin
      @(negedge clk);
      if (bus_if.bus_gnt) granted = 1;
      bus_if.bus_gnt = 0;
      bus_if.bus_rvalid = 0;
      bus_if.bus_err = 0;
      if (mem_stall) o_nstall++;
      if (mem_exc) begin
        o_nexc++;
        o_cause = mem_exc_cause;
      end
      if (bus_if.bus_req) begin
        if (o_nreq == 0) begin
          o_we = bus_if.bus_we;
          o_addr = bus_if.bus_addr;
          o_wdata = bus_if.bus_wdata;
          o_wstrb = bus_if.bus_wstrb;
        end else if ({o_we, o_addr, o_wdata, o_wstrb}
          !== {bus_if.bus_we, bus_if.bus_addr,
               bus_if.bus_wdata, bus_if.bus_wstrb})
          o_stable = 0;
        o_nreq++;
      end
      if (wb_valid) begin
        o_done = 1; o_cyc = c;
        o_res = wb_result; o_rdv = wb_rd_valid;
        o_rda = wb_rd_addr;
      end else if (bus_if.bus_req && !granted) begin
        if (gw == gd) begin
          bus_if.bus_gnt = 1;
          bus_if.bus_err = er && st;
        end else gw++;
      end else if (granted && !responded && !st) begin
        if (rw == rdl) begin
          bus_if.bus_rvalid = 1;
          bus_if.bus_rdata = rdat;
          bus_if.bus_err = er;
          responded = 1;
        end else rw++;
      end
    end
    @(posedge clk); #1;
    bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0;
    bus_if.bus_err = 0;
  endtask

  task automatic idle_cycle();
    valid_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b0;
    instr_id_in = 6'd0; mem_addr_in = 32'd0;
    rs2_value_in = 32'd0; exec_output_in = 32'd0;
    rd_addr_in = 5'd0; rd_valid_in = 1'b0;
    bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0;
    bus_if.bus_err = 0; bus_if.bus_rdata = 0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus_if.bus_req, bus_if.bus_we,
         bus_if.bus_addr, bus_if.bus_wdata,
         bus_if.bus_wstrb} !== 70'd0)
      $display("FAIL reset_bus got req=%b addr=%h wdata=%h wstrb=%b want all 0",
        bus_if.bus_req, bus_if.bus_addr,
        bus_if.bus_wdata, bus_if.bus_wstrb);
    else n_pass++;
    n_total++;
    if ({mem_exc, mem_stall, wb_valid} !== 3'b000)
      $display("FAIL reset_out got exc/stall/wbv=%b want 000",
        {mem_exc, mem_stall, wb_valid});
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nonmem();
    do_op(6'd5, 32'h0, 32'h0, 32'hCAFE0001,
          5'd9, 1'b1, 0, 0, 32'h0, 1'b0);
    n_total++;
    if (!o_done || o_cyc != 0 || o_res !== 32'hCAFE0001
        || o_rdv !== 1'b1 || o_rda !== 5'd9)
      $display("FAIL nonmem got cyc=%0d res=%h rdv=%b rda=%0d want 0 cafe0001 1 9",
        o_cyc, o_res, o_rdv, o_rda);
    else n_pass++;
    n_total++;
    if (o_nreq != 0 || o_nstall != 0)
      $display("FAIL nonmem_bus got req=%0d stall=%0d want 0 0",
        o_nreq, o_nstall);
    else n_pass++;
  endtask

  task automatic test_lw();
    idle_cycle();
    do_op(6'd22, 32'h10000010, 32'h0, 32'h0,
          5'd3, 1'b1, 0, 0, 32'hDEADBEEF, 1'b0);
    n_total++;
    if (!o_done || o_nstall != 3 || o_cyc != 3)
      $display("FAIL lw_timing got stall=%0d cyc=%0d want 3 3",
        o_nstall, o_cyc);
    else n_pass++;
    n_total++;
    if (o_res !== 32'hDEADBEEF || o_rdv !== 1'b1)
      $display("FAIL lw_result got %h rdv=%b want deadbeef 1",
        o_res, o_rdv);
    else n_pass++;
    n_total++;
    if (o_addr !== 32'h10000010 || o_we !== 1'b0
        || o_wstrb !== 4'd0)
      $display("FAIL lw_bus got addr=%h we=%b wstrb=%b want 10000010 0 0000",
        o_addr, o_we, o_wstrb);
    else n_pass++;
  endtask

  task automatic test_sb();
    idle_cycle();
    do_op(6'd25, 32'h20000003, 32'h000000A5,
          32'h0, 5'd4, 1'b1, 0, 0, 32'h0, 1'b0);
    n_total++;
    if (o_wstrb !== 4'b1000 || o_wdata !== 32'hA5A5A5A5)
      $display("FAIL sb_lanes got wstrb=%b wdata=%h want 1000 a5a5a5a5",
        o_wstrb, o_wdata);
    else n_pass++;
    n_total++;
    if (!o_done || o_rdv !== 1'b0 || o_cyc != 2
        || o_addr !== 32'h20000000 || o_we !== 1'b1)
      $display("FAIL sb_wb got rdv=%b cyc=%0d addr=%h we=%b want 0 2 20000000 1",
        o_rdv, o_cyc, o_addr, o_we);
    else n_pass++;
  endtask

  task automatic test_lb_lbu();
    do_op(6'd20, 32'h30000002, 32'h0, 32'h0,
          5'd5, 1'b1, 0, 0, 32'h00800000, 1'b0);
    n_total++;
    if (o_res !== 32'hFFFFFF80)
      $display("FAIL lb_sign got %h want ffffff80", o_res);
    else n_pass++;
    do_op(6'd23, 32'h30000002, 32'h0, 32'h0,
          5'd5, 1'b1, 0, 0, 32'h00800000, 1'b0);
    n_total++;
    if (o_res !== 32'h00000080)
      $display("FAIL lbu_zero got %h want 00000080", o_res);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    idle_cycle();
    do_op(6'd21, 32'h40000001, 32'h0, 32'h0,
          5'd6, 1'b1, 0, 0, 32'h0, 1'b0);
    n_total++;
    if (!o_done || o_cyc != 0 || o_nreq != 0
        || o_nstall != 0)
      $display("FAIL lh_mis_bus got cyc=%0d req=%0d stall=%0d want 0 0 0",
        o_cyc, o_nreq, o_nstall);
    else n_pass++;
    n_total++;
    if (o_nexc != 1 || o_cause !== 2'd0
        || o_rdv !== 1'b0)
      $display("FAIL lh_mis_exc got exc=%0d cause=%0d rdv=%b want 1 0 0",
        o_nexc, o_cause, o_rdv);
    else n_pass++;
  endtask

  task automatic test_wait_err();
    idle_cycle();
    do_op(6'd27, 32'h40000008, 32'h12345678,
          32'h0, 5'd7, 1'b0, 3, 0, 32'h0, 1'b0);
    n_total++;
    if (o_nreq != 4 || !o_stable || o_cyc != 5)
      $display("FAIL sw_wait got req=%0d stable=%0d cyc=%0d want 4 1 5",
        o_nreq, o_stable, o_cyc);
    else n_pass++;
    n_total++;
    if (o_nexc != 0 || o_wstrb !== 4'hF
        || o_wdata !== 32'h12345678)
      $display("FAIL sw_payload got exc=%0d wstrb=%b wdata=%h want 0 1111 12345678",
        o_nexc, o_wstrb, o_wdata);
    else n_pass++;
    do_op(6'd22, 32'h4000000C, 32'h0, 32'h0,
          5'd8, 1'b1, 0, 1, 32'h55AA55AA, 1'b1);
    n_total++;
    if (o_nexc != 1 || o_cause !== 2'd2
        || o_rdv !== 1'b0 || o_cyc != 4)
      $display("FAIL ld_err got exc=%0d cause=%0d rdv=%b cyc=%0d want 1 2 0 4",
        o_nexc, o_cause, o_rdv, o_cyc);
    else n_pass++;
  endtask

  task automatic test_reset_mid_resp();
    bit bad;
    idle_cycle();
    valid_in = 1'b1; instr_id_in = 6'd22;
    mem_addr_in = 32'h50000004; rd_valid_in = 1'b1;
    rd_addr_in = 5'd10;
    @(negedge clk);
    @(negedge clk);
    bus_if.bus_gnt = bus_if.bus_req;
    @(negedge clk);
    bus_if.bus_gnt = 1'b0;
    n_total++;
    if (mem_stall !== 1'b1 || bus_if.bus_req !== 1'b0)
      $display("FAIL in_resp got stall=%b req=%b want 1 0",
        mem_stall, bus_if.bus_req);
    else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata = 32'h77777777;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_if.bus_rvalid = 1'b0;
      if (wb_valid || bus_if.bus_req || mem_stall
          || mem_exc)
        bad = 1;
    end
    n_total++;
    if (bad)
      $display("FAIL stale_resp got activity after reset want none");
    else n_pass++;
    @(posedge clk); #1;
    do_op(6'd22, 32'h50000004, 32'h0, 32'h0,
          5'd10, 1'b1, 0, 0, 32'h00000011, 1'b0);
    n_total++;
    if (!o_done || o_cyc != 3 || o_res !== 32'h11)
      $display("FAIL post_reset_lw got cyc=%0d res=%h want 3 00000011",
        o_cyc, o_res);
    else n_pass++;
  endtask

  task automatic test_random_back_to_back();
    logic [5:0]  id;
    logic [31:0] a, d, ex, rdat;
    logic [4:0]  rd;
    logic        rdv, er;
    int          gd, rdl;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) != 0)
        id = 6'($urandom_range(20, 27));
      else begin
        id = 6'($urandom_range(0, 63));
        if (id >= 20 && id <= 27) id = id + 6'd20;
      end
      a = $urandom; d = $urandom; ex = $urandom;
      rdat = $urandom; rd = 5'($urandom);
      rdv = 1'($urandom);
      er = ($urandom_range(0, 7) == 0);
      gd = $urandom_range(0, 3);
      rdl = $urandom_range(0, 3);
      model(id, a, d, ex, rdv, gd, rdl, rdat, er);
      do_op(id, a, d, ex, rd, rdv, gd, rdl, rdat, er);
      n_total++;
      if (!o_done || o_cyc != e_cyc
          || o_nstall != e_nstall)
        $display("FAIL rand%0d_timing id=%0d got cyc=%0d stall=%0d want %0d %0d",
          k, id, o_cyc, o_nstall, e_cyc, e_nstall);
      else n_pass++;
      n_total++;
      if (o_nreq != e_nreq || o_nexc != e_nexc
          || (e_nexc != 0 && o_cause !== e_cause))
        $display("FAIL rand%0d_req_exc id=%0d got req=%0d exc=%0d cause=%0d want %0d %0d %0d",
          k, id, o_nreq, o_nexc, o_cause,
          e_nreq, e_nexc, e_cause);
      else n_pass++;
      n_total++;
      if (o_rdv !== e_rdv || o_rda !== rd)
        $display("FAIL rand%0d_rd id=%0d got rdv=%b rda=%0d want %b %0d",
          k, id, o_rdv, o_rda, e_rdv, rd);
      else n_pass++;
      if (!e_mem && e_nexc == 0 || e_mem && e_ld) begin
        n_total++;
        if (o_res !== e_res)
          $display("FAIL rand%0d_res id=%0d got %h want %h",
            k, id, o_res, e_res);
        else n_pass++;
      end
      if (e_mem) begin
        n_total++;
        if (o_we !== e_we || o_addr !== e_addr
            || o_wstrb !== e_wstrb || !o_stable
            || (!e_ld && o_wdata !== e_wdata))
          $display("FAIL rand%0d_bus id=%0d got we=%b addr=%h strb=%b wdata=%h want %b %h %b %h",
            k, id, o_we, o_addr, o_wstrb, o_wdata,
            e_we, e_addr, e_wstrb, e_wdata);
        else n_pass++;
      end
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_nonmem();
    test_lw();
    test_sb();
    test_lb_lbu();
    test_misaligned();
    test_wait_err();
    test_reset_mid_resp();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
